// File: rtl/show_sequencer.sv
// Show sequencer: IDLE -> INTRO ramp-up -> MUSIC -> OUTRO ramp-down, stepped by a prescaled tick.
// Optional macro SHOW_PAUSE_EN adds a PAUSE state toggled by start_btn while in MUSIC.
module show_sequencer #(
  parameter int TICK_DIV    = 50_000_000,
  parameter int MUSIC_TICKS = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       stop_btn,
  input  logic       music_done,
  output logic [1:0] light_lever,
  output logic       music_en,
  output logic [2:0] state,
  output logic       busy,
  output logic       show_done
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INTRO = 3'd1,
    ST_MUSIC = 3'd2,
    ST_OUTRO = 3'd3,
    ST_PAUSE = 3'd4
  } state_t;

  localparam int            PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TICK_LAST  = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_ZERO = PW'(0);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
  localparam logic [7:0]    MUSIC_LAST = 8'(MUSIC_TICKS);

  state_t        r_state;
  logic [1:0]    r_step;
  logic [PW-1:0] r_presc;
  logic [7:0]    r_mcnt;
  logic          r_start_q;
  logic          r_stop_q;
  logic [1:0]    r_lever;
  logic          r_music_en;
  logic          r_busy;
  logic          r_show_done;

  state_t        w_state_nx;
  logic [1:0]    w_step_nx;
  logic [1:0]    w_lever_nx;
  logic [PW-1:0] w_presc_nx;
  logic [7:0]    w_mcnt_nx;
  logic          w_freeze;
  logic          w_done_nx;
  logic          w_start_edge;
  logic          w_stop_edge;
  logic          w_tick;

  assign w_start_edge = start_btn & ~r_start_q;
  assign w_stop_edge  = stop_btn & ~r_stop_q;
  assign w_tick       = (r_presc == TICK_LAST);

  // Next state, step and music tick counter; stop beats start, music_done and tick share one exit
  always_comb begin
    w_state_nx = r_state;
    w_step_nx  = r_step;
    w_mcnt_nx  = r_mcnt;
    w_freeze   = 1'b0;
    w_done_nx  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_edge) begin
          w_state_nx = ST_INTRO;
          w_step_nx  = 2'd0;
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_INTRO: begin
        if (w_stop_edge) begin
          w_state_nx = ST_OUTRO;
          w_step_nx  = 2'd3;
        end else if (w_tick) begin
          if (r_step == 2'd3) begin
            w_state_nx = ST_MUSIC;
            w_mcnt_nx  = 8'd0;
          end else begin
            w_step_nx = r_step + 2'd1;
          end
        end else begin
          w_step_nx = r_step;
        end
      end
      ST_MUSIC: begin
        if (w_stop_edge || music_done) begin
          w_state_nx = ST_OUTRO;
          w_step_nx  = 2'd3;
`ifdef SHOW_PAUSE_EN
        end else if (w_start_edge) begin
          w_state_nx = ST_PAUSE;
          w_freeze   = 1'b1;
`endif
        end else if (w_tick) begin
          if ((r_mcnt + 8'd1) == MUSIC_LAST) begin
            w_state_nx = ST_OUTRO;
            w_step_nx  = 2'd3;
          end else begin
            w_mcnt_nx = r_mcnt + 8'd1;
          end
        end else begin
          w_mcnt_nx = r_mcnt;
        end
      end
`ifdef SHOW_PAUSE_EN
      ST_PAUSE: begin
        if (w_stop_edge) begin
          w_state_nx = ST_OUTRO;
          w_step_nx  = 2'd3;
        end else if (w_start_edge) begin
          w_state_nx = ST_MUSIC;
          w_freeze   = 1'b1;
        end else begin
          w_freeze = 1'b1;
        end
      end
`endif
      ST_OUTRO: begin
        if (w_tick) begin
          if (r_step == 2'd0) begin
            w_state_nx = ST_IDLE;
            w_done_nx  = 1'b1;
          end else begin
            w_step_nx = r_step - 2'd1;
          end
        end else begin
          w_step_nx = r_step;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_step_nx  = 2'd0;
        w_mcnt_nx  = 8'd0;
      end
    endcase
  end

  // Brightness for the upcoming state, registered alongside it
  always_comb begin
    case (w_state_nx)
      ST_INTRO, ST_OUTRO: w_lever_nx = w_step_nx;
      ST_MUSIC, ST_PAUSE: w_lever_nx = 2'd3;
      default:            w_lever_nx = 2'd0;
    endcase
  end

  // Prescaler: held while paused (and across pause/resume), restarts on any state change
  always_comb begin
    if (w_freeze) begin
      w_presc_nx = r_presc;
    end else if ((w_state_nx != r_state) || w_tick) begin
      w_presc_nx = PRESC_ZERO;
    end else begin
      w_presc_nx = r_presc + PRESC_ONE;
    end
  end

  // State and output registers; edge history resets high so a held button is not an edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_step      <= 2'd0;
      r_presc     <= PRESC_ZERO;
      r_mcnt      <= 8'd0;
      r_start_q   <= 1'b1;
      r_stop_q    <= 1'b1;
      r_lever     <= 2'd0;
      r_music_en  <= 1'b0;
      r_busy      <= 1'b0;
      r_show_done <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_step      <= w_step_nx;
      r_presc     <= w_presc_nx;
      r_mcnt      <= w_mcnt_nx;
      r_start_q   <= start_btn;
      r_stop_q    <= stop_btn;
      r_lever     <= w_lever_nx;
      r_music_en  <= (w_state_nx == ST_MUSIC);
      r_busy      <= (w_state_nx != ST_IDLE);
      r_show_done <= w_done_nx;
    end
  end

  assign light_lever = r_lever;
  assign music_en    = r_music_en;
  assign state       = r_state;
  assign busy        = r_busy;
  assign show_done   = r_show_done;

endmodule

// File: tb/tb_show_sequencer.sv
// Directed bench for show_sequencer with TICK_DIV=4, MUSIC_TICKS=5; outputs packed as
// {state, light_lever, music_en, busy, show_done} and compared to hand-derived values.
module tb_show_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_btn = 1'b0;
  logic       stop_btn = 1'b0;
  logic       music_done = 1'b0;
  logic [1:0] light_lever;
  logic       music_en;
  logic [2:0] state;
  logic       busy;
  logic       show_done;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] obs;

  show_sequencer #(.TICK_DIV(4), .MUSIC_TICKS(5)) dut (
    .clk(clk), .rst(rst), .start_btn(start_btn), .stop_btn(stop_btn),
    .music_done(music_done), .light_lever(light_lever), .music_en(music_en),
    .state(state), .busy(busy), .show_done(show_done)
  );

  always #5 clk = ~clk;

  assign obs = {state, light_lever, music_en, busy, show_done};

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%b exp=%b (state,lever,en,busy,done)", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [7:0] pk(input logic [2:0] s, input logic [1:0] l,
                                    input logic e, input logic b, input logic d);
    return {s, l, e, b, d};
  endfunction

  // Full show, k edges after the start edge: INTRO 16, MUSIC 20, OUTRO 16, then done pulse
  function automatic logic [7:0] exp_full(input int k);
    if (k < 16)       return pk(3'd1, 2'(k / 4), 1'b0, 1'b1, 1'b0);
    else if (k < 36)  return pk(3'd2, 2'd3, 1'b1, 1'b1, 1'b0);
    else if (k < 52)  return pk(3'd3, 2'(3 - (k - 36) / 4), 1'b0, 1'b1, 1'b0);
    else if (k == 52) return pk(3'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    else              return pk(3'd0, 2'd0, 1'b0, 1'b0, 1'b0);
  endfunction

  // OUTRO ramp, j edges after entry
  function automatic logic [7:0] exp_outro(input int j);
    if (j < 16) return pk(3'd3, 2'(3 - j / 4), 1'b0, 1'b1, 1'b0);
    else        return pk(3'd0, 2'd0, 1'b0, 1'b0, 1'b1);
  endfunction

  initial begin
    #1 rst = 1'b0;
    #1 check_val("reset_async", obs, 8'd0);
    @(posedge clk);
    #1 check_val("reset_held", obs, 8'd0);
    rst = 1'b1;
    cyc(2);
    check_val("idle_after_reset", obs, 8'd0);

    stop_btn = 1'b1;
    cyc(1);
    stop_btn = 1'b0;
    check_val("stop_in_idle", obs, 8'd0);
    cyc(1);

    // Full show with ignored start/music_done/stop events sprinkled in
    start_btn = 1'b1;
    cyc(1);
    for (int k = 0; k <= 53; k++) begin
      check_val($sformatf("full_k%0d", k), obs, exp_full(k));
      case (k)
        0, 6, 41: start_btn = 1'b0;
        5, 40:    start_btn = 1'b1;
        9:        music_done = 1'b1;
        10:       music_done = 1'b0;
        44:       stop_btn = 1'b1;
        45:       stop_btn = 1'b0;
`ifndef SHOW_PAUSE_EN
        22:       start_btn = 1'b1;
        23:       start_btn = 1'b0;
`endif
        default:  ;
      endcase
      if (k < 53) cyc(1);
    end

    // Stop during INTRO at lever 2
    start_btn = 1'b1;
    cyc(1);
    start_btn = 1'b0;
    cyc(8);
    check_val("intro_lever2", obs, pk(3'd1, 2'd2, 1'b0, 1'b1, 1'b0));
    stop_btn = 1'b1;
    cyc(1);
    stop_btn = 1'b0;
    for (int j = 0; j <= 16; j++) begin
      check_val($sformatf("stop_outro_j%0d", j), obs, exp_outro(j));
      if (j < 16) cyc(1);
    end
    cyc(1);

    // Early tune end
    start_btn = 1'b1;
    cyc(1);
    start_btn = 1'b0;
    cyc(17);
    check_val("early_music", obs, pk(3'd2, 2'd3, 1'b1, 1'b1, 1'b0));
    music_done = 1'b1;
    cyc(1);
    music_done = 1'b0;
    check_val("early_outro", obs, pk(3'd3, 2'd3, 1'b0, 1'b1, 1'b0));
    cyc(15);
    check_val("early_outro_end", obs, pk(3'd3, 2'd0, 1'b0, 1'b1, 1'b0));
    cyc(1);
    check_val("early_done", obs, pk(3'd0, 2'd0, 1'b0, 1'b0, 1'b1));
    cyc(1);

    // Start and stop on the same edge in MUSIC
    start_btn = 1'b1;
    cyc(1);
    start_btn = 1'b0;
    cyc(17);
    start_btn = 1'b1;
    stop_btn = 1'b1;
    cyc(1);
    start_btn = 1'b0;
    stop_btn = 1'b0;
    check_val("both_edges_outro", obs, pk(3'd3, 2'd3, 1'b0, 1'b1, 1'b0));
    cyc(16);
    check_val("both_edges_done", obs, pk(3'd0, 2'd0, 1'b0, 1'b0, 1'b1));
    cyc(1);

`ifdef SHOW_PAUSE_EN
    // Pause after two music ticks, hold 50 cycles, resume for three more ticks
    start_btn = 1'b1;
    cyc(1);
    start_btn = 1'b0;
    cyc(24);
    check_val("pause_pre_music", obs, pk(3'd2, 2'd3, 1'b1, 1'b1, 1'b0));
    start_btn = 1'b1;
    cyc(1);
    start_btn = 1'b0;
    for (int p = 0; p < 50; p++) begin
      check_val($sformatf("pause_p%0d", p), obs, pk(3'd4, 2'd3, 1'b0, 1'b1, 1'b0));
      if (p == 5) music_done = 1'b1;
      if (p == 6) music_done = 1'b0;
      if (p == 49) start_btn = 1'b1;
      cyc(1);
    end
    start_btn = 1'b0;
    check_val("resume_music", obs, pk(3'd2, 2'd3, 1'b1, 1'b1, 1'b0));
    cyc(11);
    check_val("resume_last_music", obs, pk(3'd2, 2'd3, 1'b1, 1'b1, 1'b0));
    cyc(1);
    check_val("resume_outro", obs, pk(3'd3, 2'd3, 1'b0, 1'b1, 1'b0));
    cyc(16);
    check_val("resume_done", obs, pk(3'd0, 2'd0, 1'b0, 1'b0, 1'b1));
    cyc(1);
`endif

    // Reset mid-MUSIC with start held through release
    start_btn = 1'b1;
    cyc(1);
    start_btn = 1'b0;
    cyc(18);
    check_val("rst_pre_music", obs, pk(3'd2, 2'd3, 1'b1, 1'b1, 1'b0));
    start_btn = 1'b1;
    rst = 1'b0;
    #2 check_val("rst_mid_async", obs, 8'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    for (int r = 0; r < 4; r++) begin
      cyc(1);
      check_val($sformatf("rst_hold_idle_%0d", r), obs, 8'd0);
    end
    start_btn = 1'b0;
    cyc(1);
    start_btn = 1'b1;
    cyc(1);
    start_btn = 1'b0;
    check_val("rst_recover_intro", obs, pk(3'd1, 2'd0, 1'b0, 1'b1, 1'b0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
